// File: rtl/fft_r4_seq.sv
// fft_r4_seq: frame sequencer for an in-place radix-4 DIF FFT of N = 4^STAGES points.
// Optional macro FFT_INV_EN adds the inv input and tw_conj output for inverse transforms.
module fft_r4_seq #(
  parameter int STAGES = 4,
  parameter int AW     = 2 * STAGES,
  parameter int LAT    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din_valid,
  output logic            din_ready,
  output logic            ld_we,
  output logic [AW-1:0]   ld_addr,
  output logic            rd_en,
  output logic [4*AW-1:0] rd_addr,
  output logic [AW-1:0]   tw_exp,
  output logic            wr_en,
  output logic [4*AW-1:0] wr_addr,
  output logic [2:0]      stage,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [AW-1:0]   dout_addr,
  output logic            dout_last,
  output logic            busy,
`ifdef FFT_INV_EN
  input  logic            inv,
  output logic            tw_conj,
`endif
  output logic            done
);

  localparam int N  = 1 << AW;
  localparam int NB = N / 4;
  localparam int PW = 4 * AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMP, S_DRAIN, S_UNLOAD} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [3:0]    dcnt_q, dcnt_d;
  logic [2:0]    stage_q, stage_d;
  logic          done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      stage_q <= stage_d;
      done_q  <= done_d;
    end
  end

  // cnt_q is the load count, the butterfly index b, or the unload index j depending on state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dcnt_d     = dcnt_q;
    stage_d    = stage_q;
    done_d     = 1'b0;
    din_ready  = 1'b0;
    ld_we      = 1'b0;
    ld_addr    = '0;
    rd_en      = 1'b0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (din_valid) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        din_ready = 1'b1;
        ld_we     = din_valid;
        ld_addr   = cnt_q;
        if (din_valid) begin
          if (cnt_q == AW'(N - 1)) begin
            state_d = S_COMP;
            cnt_d   = '0;
            stage_d = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      S_COMP: begin
        rd_en = 1'b1;
        if (cnt_q == AW'(NB - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          dcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == 4'(LAT - 1)) begin
          dcnt_d = '0;
          if (stage_q == 3'(STAGES - 1)) begin
            state_d = S_UNLOAD;
            stage_d = '0;
          end else begin
            state_d = S_COMP;
            stage_d = stage_q + 3'd1;
          end
        end else begin
          dcnt_d = dcnt_q + 4'd1;
        end
      end
      S_UNLOAD: begin
        dout_valid = 1'b1;
        dout_last  = (cnt_q == AW'(N - 1));
        if (dout_ready) begin
          if (cnt_q == AW'(N - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Butterfly addressing: sh = log2(span), base = g*4*span + k.
  logic [3:0]    sh;
  logic [AW-1:0] span_mask, k_idx, base;

  always_comb begin
    sh        = 4'(2 * (STAGES - 1)) - {stage_q, 1'b0};
    span_mask = (AW'(1) << sh) - AW'(1);
    k_idx     = cnt_q & span_mask;
    base      = ((cnt_q >> sh) << (sh + 4'd2)) | k_idx;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_addr[gi*AW +: AW] = rd_en ? (base | (AW'(gi) << sh)) : '0;
  end

  assign tw_exp = rd_en ? (k_idx << {stage_q, 1'b0}) : '0;

  logic [AW-1:0] rev;
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_rev
    assign rev[2*gi +: 2] = cnt_q[2*(STAGES-1-gi) +: 2];
  end

  assign dout_addr = dout_valid ? rev : '0;

  // Write-back mirrors the read issue exactly LAT cycles later, whatever the state.
  logic [PW-1:0] pipe_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {rd_en, rd_addr};
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign wr_en   = pipe_q[LAT-1][PW-1];
  assign wr_addr = pipe_q[LAT-1][PW-2:0];

  assign stage = (state_q == S_COMP || state_q == S_DRAIN) ? stage_q : 3'd0;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;

`ifdef FFT_INV_EN
  logic inv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (state_q == S_IDLE && din_valid) begin
      inv_q <= inv;
    end
  end

  assign tw_conj = (state_q == S_COMP) & inv_q;
`endif

endmodule

// File: tb/tb_fft_r4_seq.sv
// tb_fft_r4_seq: randomized bench comparing fft_r4_seq against an arithmetic FFT-schedule model.
// Two instances: STAGES=4/LAT=3 for the main frames, STAGES=2/LAT=5 for the drain timing.
module tb_fft_r4_seq;

  localparam int S1 = 4, L1 = 3, AW1 = 8, N1 = 256, NB1 = 64;
  localparam int S2 = 2, L2 = 5, AW2 = 4, N2 = 16, NB2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, din_valid, dout_ready;
  logic             din_ready, ld_we, rd_en, wr_en, dout_valid, dout_last, busy, done;
  logic [AW1-1:0]   ld_addr, tw_exp, dout_addr;
  logic [4*AW1-1:0] rd_addr, wr_addr;
  logic [2:0]       stage;

  logic             din_valid2, dout_ready2;
  logic             din_ready2, ld_we2, rd_en2, wr_en2, dout_valid2, dout_last2, busy2, done2;
  logic [AW2-1:0]   ld_addr2, tw_exp2, dout_addr2;
  logic [4*AW2-1:0] rd_addr2, wr_addr2;
  logic [2:0]       stage2;

`ifdef FFT_INV_EN
  logic inv, tw_conj, tw_conj2;
`endif

  int   checks = 0;
  int   errors = 0;
  logic exp_inv;

  fft_r4_seq #(.STAGES(S1), .LAT(L1)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready), .ld_we(ld_we),
    .ld_addr(ld_addr), .rd_en(rd_en), .rd_addr(rd_addr), .tw_exp(tw_exp), .wr_en(wr_en),
    .wr_addr(wr_addr), .stage(stage), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_addr(dout_addr), .dout_last(dout_last), .busy(busy),
`ifdef FFT_INV_EN
    .inv(inv), .tw_conj(tw_conj),
`endif
    .done(done)
  );

  fft_r4_seq #(.STAGES(S2), .LAT(L2)) dut2 (
    .clk(clk), .rst(rst), .din_valid(din_valid2), .din_ready(din_ready2), .ld_we(ld_we2),
    .ld_addr(ld_addr2), .rd_en(rd_en2), .rd_addr(rd_addr2), .tw_exp(tw_exp2), .wr_en(wr_en2),
    .wr_addr(wr_addr2), .stage(stage2), .dout_valid(dout_valid2), .dout_ready(dout_ready2),
    .dout_addr(dout_addr2), .dout_last(dout_last2), .busy(busy2),
`ifdef FFT_INV_EN
    .inv(1'b0), .tw_conj(tw_conj2),
`endif
    .done(done2)
  );

  // ---------------- reference model (plain FFT schedule arithmetic) ----------------
  function automatic int ref_rd(int st, int s, int b, int m);
    int span, g, k;
    span = 4 ** (st - 1 - s);
    g    = b / span;
    k    = b % span;
    return g * 4 * span + k + m * span;
  endfunction

  function automatic int ref_rev(int st, int j);
    int r, v;
    r = 0;
    v = j;
    for (int d = 0; d < st; d++) begin
      r = r * 4 + v % 4;
      v = v / 4;
    end
    return r;
  endfunction

  // u = cycle index counted from the first COMP cycle of a frame
  function automatic logic exp_en(int st, int lat, int u);
    int nb;
    nb = (4 ** st) / 4;
    if (u < 0 || u >= st * (nb + lat)) return 1'b0;
    return ((u % (nb + lat)) < nb);
  endfunction

  function automatic logic [31:0] exp_rdv(int st, int lat, int u);
    logic [31:0] v;
    int nb, s, r;
    v  = '0;
    nb = (4 ** st) / 4;
    if (!exp_en(st, lat, u)) return v;
    s = u / (nb + lat);
    r = u % (nb + lat);
    for (int m = 0; m < 4; m++) v = v | (32'(ref_rd(st, s, r, m)) << (m * 2 * st));
    return v;
  endfunction

  function automatic int exp_tw(int st, int lat, int u);
    int nb, s, r, span;
    nb = (4 ** st) / 4;
    if (!exp_en(st, lat, u)) return 0;
    s    = u / (nb + lat);
    r    = u % (nb + lat);
    span = 4 ** (st - 1 - s);
    return ((r % span) * (4 ** s)) % (4 ** st);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_start(input logic inv_v);
    exp_inv   = inv_v;
`ifdef FFT_INV_EN
    inv       = inv_v;
`endif
    din_valid = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_state: din_ready=%b busy=%b expected 0 0", din_ready, busy);
    end
    tick;
`ifdef FFT_INV_EN
    inv = ~inv_v;
`endif
    din_valid = 1'b0;
    #1;
    checks++;
    if (din_ready !== 1'b1 || busy !== 1'b1 || ld_we !== 1'b0) begin
      errors++;
      $display("FAIL load_entry: din_ready=%b busy=%b ld_we=%b expected 1 1 0", din_ready, busy, ld_we);
    end
    $display("frame start: inv=%0b", exp_inv);
  endtask

  task automatic test_reset;
    rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; din_valid2 = 1'b0; dout_ready2 = 1'b0;
`ifdef FFT_INV_EN
    inv = 1'b0;
`endif
    tick;
    tick;
    #1;
    checks++;
    if ({din_ready, ld_we, rd_en, wr_en, dout_valid, dout_last, busy, done} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {din_ready, ld_we, rd_en, wr_en, dout_valid, dout_last, busy, done});
    end
    checks++;
    if ({ld_addr, rd_addr, tw_exp, wr_addr, stage, dout_addr} !== '0) begin
      errors++;
      $display("FAIL reset_buses: got rd=%h wr=%h ld=%h tw=%h stage=%0d dout=%h expected all 0",
               rd_addr, wr_addr, ld_addr, tw_exp, stage, dout_addr);
    end
    checks++;
    if (busy2 !== 1'b0 || wr_en2 !== 1'b0 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut2: busy=%b wr_en=%b done=%b expected 0 0 0", busy2, wr_en2, done2);
    end
    rst = 1'b0;
    $display("test_reset: done");
    test_start(1'b0);
  endtask

  task automatic test_load(input int mode);
    int ecnt, cyc;
    ecnt = 0;
    cyc  = 0;
    while (ecnt < N1 && cyc < 4 * N1) begin
      din_valid  = (mode == 0) ? 1'((cyc % 2) == 0) : 1'($urandom_range(0, 2) != 0);
      dout_ready = 1'($urandom);
      #1;
      checks++;
      if (din_ready !== 1'b1 || ld_we !== din_valid || (din_valid && ld_addr !== ecnt[7:0])) begin
        errors++;
        $display("FAIL load: cycle %0d ready=%b we=%b addr=%0d expected ready=1 we=%b addr=%0d",
                 cyc, din_ready, ld_we, ld_addr, din_valid, ecnt);
      end
      tick;
      if (din_valid) ecnt++;
      cyc++;
    end
    din_valid = 1'b0;
    #1;
    checks++;
    if (ecnt != N1 || rd_en !== 1'b1 || din_ready !== 1'b0 || stage !== 3'd0) begin
      errors++;
      $display("FAIL load_to_comp: accepted=%0d rd_en=%b din_ready=%b stage=%0d expected %0d 1 0 0",
               ecnt, rd_en, din_ready, stage, N1);
    end
    $display("test_load: mode %0d, %0d samples in %0d cycles", mode, ecnt, cyc);
  endtask

  task automatic test_comp(input int stop_t);
    int total;
    total = S1 * (NB1 + L1);
    for (int t = 0; t < total; t++) begin
      logic [31:0] e_rd, e_wr, k_rd;
      logic [7:0]  e_tw, k_tw;
      logic        e_en, e_wen;
      int          s, r;
      s     = t / (NB1 + L1);
      r     = t % (NB1 + L1);
      e_en  = exp_en(S1, L1, t);
      e_rd  = exp_rdv(S1, L1, t);
      e_tw  = 8'(exp_tw(S1, L1, t));
      e_wen = exp_en(S1, L1, t - L1);
      e_wr  = exp_rdv(S1, L1, t - L1);
      din_valid  = 1'($urandom);
      dout_ready = 1'($urandom);
      #1;
      checks++;
      if (rd_en !== e_en || rd_addr !== e_rd) begin
        errors++;
        $display("FAIL comp_rd: t=%0d rd_en=%b rd_addr=%h expected %b %h", t, rd_en, rd_addr, e_en, e_rd);
      end
      checks++;
      if (tw_exp !== e_tw) begin
        errors++;
        $display("FAIL comp_tw: t=%0d tw_exp=%0d expected %0d", t, tw_exp, e_tw);
      end
      checks++;
      if (stage !== 3'(s)) begin
        errors++;
        $display("FAIL comp_stage: t=%0d stage=%0d expected %0d", t, stage, s);
      end
      checks++;
      if (wr_en !== e_wen || wr_addr !== e_wr) begin
        errors++;
        $display("FAIL comp_wr: t=%0d wr_en=%b wr_addr=%h expected %b %h", t, wr_en, wr_addr, e_wen, e_wr);
      end
      checks++;
      if (din_ready !== 1'b0 || ld_we !== 1'b0 || dout_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL comp_ctrl: t=%0d din_ready=%b ld_we=%b dout_valid=%b busy=%b expected 0 0 0 1",
                 t, din_ready, ld_we, dout_valid, busy);
      end
`ifdef FFT_INV_EN
      checks++;
      if (tw_conj !== (exp_inv & e_en)) begin
        errors++;
        $display("FAIL comp_conj: t=%0d tw_conj=%b expected %b", t, tw_conj, exp_inv & e_en);
      end
`endif
      if ((s == 0 && r == 1) || (s == 1 && r == 17) || (s == 3 && r == 5)) begin
        k_rd = (s == 0) ? {8'd193, 8'd129, 8'd65, 8'd1} :
               (s == 1) ? {8'd113, 8'd97, 8'd81, 8'd65} : {8'd23, 8'd22, 8'd21, 8'd20};
        k_tw = (s == 0) ? 8'd1 : (s == 1) ? 8'd4 : 8'd0;
        checks++;
        if (rd_addr !== k_rd || tw_exp !== k_tw) begin
          errors++;
          $display("FAIL comp_point: s=%0d b=%0d rd_addr=%h tw=%0d expected %h %0d",
                   s, r, rd_addr, tw_exp, k_rd, k_tw);
        end
      end
      if (t == stop_t) return;
      tick;
    end
    din_valid = 1'b0;
    $display("test_comp: %0d compute/drain cycles", total);
  endtask

  task automatic test_unload(input bit stall);
    int j, cyc, held;
    j    = 0;
    cyc  = 0;
    held = 0;
    while (j < N1 && cyc < 8 * N1) begin
      logic [7:0] ea;
      if (stall && j == 1 && held < 3) begin
        dout_ready = 1'b0;
        held++;
      end else begin
        dout_ready = 1'($urandom_range(0, 3) != 0);
      end
      din_valid = 1'($urandom);
      ea = 8'(ref_rev(S1, j));
      #1;
      checks++;
      if (dout_valid !== 1'b1 || dout_addr !== ea || dout_last !== (j == N1 - 1) || done !== 1'b0 ||
          busy !== 1'b1 || din_ready !== 1'b0 || rd_en !== 1'b0) begin
        errors++;
        $display("FAIL unload: j=%0d valid=%b addr=%0d last=%b done=%b busy=%b expected 1 %0d %b 0 1",
                 j, dout_valid, dout_addr, dout_last, done, busy, ea, (j == N1 - 1));
      end
      if (stall && j == 1 && !dout_ready) begin
        checks++;
        if (dout_addr !== 8'd64) begin
          errors++;
          $display("FAIL unload_hold: dout_addr=%0d expected 64", dout_addr);
        end
      end
      if (j == 4) begin
        checks++;
        if (dout_addr !== 8'd16) begin
          errors++;
          $display("FAIL unload_j4: dout_addr=%0d expected 16", dout_addr);
        end
      end
      tick;
      if (dout_ready) j++;
      cyc++;
    end
    dout_ready = 1'b0;
    din_valid  = 1'b0;
    #1;
    checks++;
    if (j != N1 || done !== 1'b1 || busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL unload_done: beats=%0d done=%b busy=%b dout_valid=%b expected %0d 1 0 0",
               j, done, busy, dout_valid, N1);
    end
    tick;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b expected 0", done);
    end
    $display("test_unload: %0d beats in %0d cycles", j, cyc);
  endtask

  task automatic test_drain;
    int total;
    total = S2 * (NB2 + L2);
    din_valid2 = 1'b1;
    tick;
    for (int i = 0; i < N2; i++) begin
      #1;
      checks++;
      if (din_ready2 !== 1'b1 || ld_we2 !== 1'b1 || ld_addr2 !== 4'(i)) begin
        errors++;
        $display("FAIL drain_load: i=%0d ready=%b we=%b addr=%0d expected 1 1 %0d",
                 i, din_ready2, ld_we2, ld_addr2, i);
      end
      tick;
    end
    din_valid2 = 1'b0;
    for (int t = 0; t < total; t++) begin
      logic [31:0] e32, w32;
      logic [15:0] e16, w16;
      logic [3:0]  etw;
      e32 = exp_rdv(S2, L2, t);
      e16 = e32[15:0];
      w32 = exp_rdv(S2, L2, t - L2);
      w16 = w32[15:0];
      etw = 4'(exp_tw(S2, L2, t));
      #1;
      checks++;
      if (rd_en2 !== exp_en(S2, L2, t) || rd_addr2 !== e16 || tw_exp2 !== etw) begin
        errors++;
        $display("FAIL drain_rd: t=%0d rd_en=%b rd_addr=%h tw=%0d expected %b %h %0d",
                 t, rd_en2, rd_addr2, tw_exp2, exp_en(S2, L2, t), e16, etw);
      end
      checks++;
      if (wr_en2 !== exp_en(S2, L2, t - L2) || wr_addr2 !== w16) begin
        errors++;
        $display("FAIL drain_wr: t=%0d wr_en=%b wr_addr=%h expected %b %h",
                 t, wr_en2, wr_addr2, exp_en(S2, L2, t - L2), w16);
      end
      checks++;
      if (stage2 !== 3'(t / (NB2 + L2)) || dout_valid2 !== 1'b0 || busy2 !== 1'b1) begin
        errors++;
        $display("FAIL drain_ctrl: t=%0d stage=%0d dout_valid=%b busy=%b expected %0d 0 1",
                 t, stage2, dout_valid2, busy2, t / (NB2 + L2));
      end
`ifdef FFT_INV_EN
      checks++;
      if (tw_conj2 !== 1'b0) begin
        errors++;
        $display("FAIL drain_conj: t=%0d tw_conj=%b expected 0", t, tw_conj2);
      end
`endif
      tick;
    end
    dout_ready2 = 1'b1;
    for (int j = 0; j < N2; j++) begin
      #1;
      checks++;
      if (dout_valid2 !== 1'b1 || dout_addr2 !== 4'(ref_rev(S2, j)) || dout_last2 !== (j == N2 - 1)) begin
        errors++;
        $display("FAIL drain_unload: j=%0d valid=%b addr=%0d last=%b expected 1 %0d %b",
                 j, dout_valid2, dout_addr2, dout_last2, ref_rev(S2, j), (j == N2 - 1));
      end
      tick;
    end
    dout_ready2 = 1'b0;
    #1;
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL drain_done: done=%b busy=%b expected 1 0", done2, busy2);
    end
    $display("test_drain: %0d compute/drain cycles for STAGES=%0d LAT=%0d", total, S2, L2);
  endtask

  task automatic test_abort;
    test_start(1'b1);
    test_load(1);
    test_comp(2 * (NB1 + L1) + 10);
    rst = 1'b1;
    tick;
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0 || stage !== 3'd0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort: wr_en=%b busy=%b rd_en=%b stage=%0d din_ready=%b expected 0 0 0 0 0",
               wr_en, busy, rd_en, stage, din_ready);
    end
    rst = 1'b0;
    $display("test_abort: reset during stage 2");
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 2; f++) begin
      test_start((f == 0) ? 1'b1 : 1'($urandom));
      test_load(1);
      test_comp(-1);
      test_unload(1'b0);
    end
    $display("test_back_to_back: 2 frames");
  endtask

  initial begin
    test_reset;
    test_load(0);
    test_comp(-1);
    test_unload(1'b1);
    test_drain;
    test_abort;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
